// File: rtl/seg_scan.sv
// Multiplexed scan driver for an N-digit common-cathode 7-segment display.
// Frame-synchronous display updates, anti-ghosting dead time, leading-zero blanking.
module seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  lz_en,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp;
    logic [4*DIGITS-1:0] pend;
    logic                pend_v;

    logic                slot_end;
    logic                wrap;
    logic [DIGITS-1:0]   lead_zero;
    logic [DIGITS-1:0]   sel_onehot;
    logic [3:0]          cur_num;
    logic                supp;
    logic                lit;
    logic                zero_run;

    assign slot_end = (cnt == CW'(SCAN_DIV - 1));
    assign wrap     = slot_end && (idx == IW'(DIGITS - 1));

    // lead_zero[k]: every nibble from the top down to k is zero
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (disp[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
        cur_num         = disp[4*idx +: 4];
        supp            = lz_en && (idx != '0) && lead_zero[idx];
        lit             = (cnt >= CW'(DEAD)) && !supp;
    end

    // Prescaler, digit index and frame-synchronous display buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            // disp only moves at the frame boundary so a frame never tears
            if (wrap) begin
                if (load) begin
                    disp <= data_in;
                end else if (pend_v) begin
                    disp <= pend;
                end else begin
                    disp <= disp;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= data_in;
                pend_v <= 1'b1;
            end else begin
                pend_v <= pend_v;
            end
        end
    end

    // Registered outputs reflect the state of the previous cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num        <= 4'd0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            num        <= cur_num;
            dig_sel    <= lit ? sel_onehot : '0;
            frame_done <= (cnt == '0) && (idx == '0);
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: the driver pushes per-cycle expectations from a
// frame-level model; a monitor pops and compares after every clock edge.
module tb_seg_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEAD     = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic        lz_en = 1'b0;
    logic [3:0]  num;
    logic [3:0]  dig_sel;
    logic        frame_done;

    seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .lz_en      (lz_en),
        .num        (num),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          s = 0;
    logic [15:0] mdisp = 16'd0;
    logic [15:0] flast = 16'd0;
    logic        fany = 1'b0;
    logic        lz_r = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, queue the response to the next rising edge
    task automatic cyc(input logic ld, input logic [15:0] d, input logic lz);
        int          cnt;
        int          idx;
        logic [15:0] shifted;
        logic        supp;
        exp_t        e;
        load    = ld;
        data_in = d;
        lz_en   = lz;
        cnt     = s % SCAN_DIV;
        idx     = (s / SCAN_DIV) % DIGITS;
        shifted = mdisp >> (4 * idx);
        supp    = lz && (idx != 0) && (shifted == 16'd0);
        e.num   = shifted[3:0];
        e.sel   = (cnt >= DEAD && !supp) ? 4'(1 << idx) : 4'd0;
        e.fd    = (s % FRAME == 0);
        sbq.push_back(e);
        // Last load seen anywhere in a frame (wrap cycle included) is shown next frame
        if (ld) begin
            flast = d;
            fany  = 1'b1;
        end
        if (s % FRAME == FRAME - 1) begin
            if (fany) mdisp = flast;
            fany = 1'b0;
        end
        s++;
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input logic lz);
        while (s < target) cyc(1'b0, 16'($urandom), lz);
    endtask

    // Monitor: compare every output sample against the queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("num", 32'(num), 32'(mon_e.num));
                chk("dig_sel", 32'(dig_sel), 32'(mon_e.sel));
                chk("frame_done", 32'(frame_done), 32'(mon_e.fd));
                chk("dig_sel_onehot", 32'($countones(dig_sel) <= 1), 32'd1);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_num", 32'(num), 32'd0);
        chk("reset_dig_sel", 32'(dig_sel), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Idle frames, then a mid-frame load
        run_until(2 * FRAME, 1'b0);
        run_until(74, 1'b0);
        cyc(1'b1, 16'h1234, 1'b0);
        run_until(4 * FRAME, 1'b0);

        // Two loads in one frame; then a load on the wrap cycle
        run_until(130, 1'b0);
        cyc(1'b1, 16'h1111, 1'b0);
        run_until(140, 1'b0);
        cyc(1'b1, 16'h2222, 1'b0);
        run_until(6 * FRAME - 1, 1'b0);
        cyc(1'b1, 16'h3333, 1'b0);
        run_until(7 * FRAME, 1'b0);

        // Leading-zero blanking
        run_until(230, 1'b1);
        cyc(1'b1, 16'h0050, 1'b1);
        run_until(9 * FRAME, 1'b1);
        run_until(260, 1'b1);
        cyc(1'b1, 16'h0000, 1'b1);
        run_until(10 * FRAME, 1'b1);

        // Asynchronous reset while a load is pending
        run_until(330, 1'b0);
        cyc(1'b1, 16'h9876, 1'b0);
        run_until(364, 1'b0);
        cyc(1'b1, 16'hABCD, 1'b0);
        chk("pre_rst_dig_sel", 32'(dig_sel), 32'h2);
        chk("pre_rst_num", 32'(num), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_num", 32'(num), 32'd0);
        chk("async_rst_dig_sel", 32'(dig_sel), 32'd0);
        chk("async_rst_frame_done", 32'(frame_done), 32'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        s     = 0;
        mdisp = 16'd0;
        fany  = 1'b0;
        run_until(2 * FRAME, 1'b0);

        // Random loads and lz_en toggles
        for (int i = 0; i < 1000 * FRAME; i++) begin
            if ($urandom_range(7, 0) == 0) lz_r = ~lz_r;
            cyc($urandom_range(15, 0) == 0, 16'($urandom), lz_r);
        end

        load = 1'b0;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
